// File: rtl/prog_loader.sv
// prog_loader: streams 9-bit instruction words into instruction memory from a
// programmed base address, then starts the core by pulsing the fetch unit's init.
// It also holds fetch_unit_en low while the memory is only partially written.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load_start/base/len        load request (len 1..2^ADDR_W)
//   in_valid/in_data/in_ready  instruction word stream
//   halt                       core halted; return to IDLE (RUN only)
//   imem_we/waddr/wdata        registered instruction-memory write port
//   init/start_address         fetch unit start pulse and start PC
//   fetch_unit_en              fetch/PC advance enable
//   busy, error                status; error is sticky until the next accepted load
//
// state  | meaning
// IDLE   | core stopped, waiting for a load request
// LOAD   | accepting words, one write per beat
// LAUNCH | one cycle: last write and init pulse together
// RUN    | core fetching; halt or a new load leaves
module prog_loader #(
  parameter int ADDR_W = 9,
  parameter int INST_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_data,
  output logic              in_ready,
  input  logic              halt,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              init,
  output logic [ADDR_W-1:0] start_address,
  output logic              fetch_unit_en,
  output logic              busy,
  output logic              error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_LAUNCH = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              req;
  logic              len_ok;
  logic              beat;

  assign req      = load_start && ((state == S_IDLE) || (state == S_RUN));
  assign len_ok   = (load_len != '0) && (load_len <= MAX_LEN);
  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_LAUNCH);
  assign beat     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr          <= '0;
      remaining     <= '0;
      imem_we       <= 1'b0;
      imem_waddr    <= '0;
      imem_wdata    <= '0;
      init          <= 1'b0;
      start_address <= '0;
      fetch_unit_en <= 1'b0;
      error         <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      init    <= 1'b0;

      if (beat) begin
        imem_we    <= 1'b1;
        imem_waddr <= addr;
        imem_wdata <= in_data;
        addr       <= addr + 1'b1;
        remaining  <= remaining - ONE;
      end

      case (state)
        S_IDLE, S_RUN: begin
          if (req && len_ok) begin
            error         <= 1'b0;
            addr          <= load_base;
            remaining     <= load_len;
            start_address <= load_base;
            fetch_unit_en <= 1'b0;
            state         <= S_LOAD;
          end else begin
            // A rejected request does not block a simultaneous halt.
            if (req) error <= 1'b1;
            if ((state == S_RUN) && halt) begin
              fetch_unit_en <= 1'b0;
              state         <= S_IDLE;
            end
          end
        end
        S_LOAD: begin
          if (beat && (remaining == ONE)) begin
            // init lines up with the final write so memory is complete
            // before the fetch unit's first read.
            init          <= 1'b1;
            fetch_unit_en <= 1'b1;
            state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_RUN;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start;
  logic [8:0] load_base;
  logic [9:0] load_len;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_ready;
  logic       halt;
  logic       imem_we;
  logic [8:0] imem_waddr;
  logic [8:0] imem_wdata;
  logic       init;
  logic [8:0] start_address;
  logic       fetch_unit_en;
  logic       busy;
  logic       error;

  int n_checks = 0;
  int n_pass   = 0;

  prog_loader #(.ADDR_W(9), .INST_W(9)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_start    (load_start),
    .load_base     (load_base),
    .load_len      (load_len),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .halt          (halt),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .init          (init),
    .start_address (start_address),
    .fetch_unit_en (fetch_unit_en),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    int'(imem_we), 0);
    chk({tag, "_waddr"}, int'(imem_waddr), 0);
    chk({tag, "_wdata"}, int'(imem_wdata), 0);
    chk({tag, "_init"},  int'(init), 0);
    chk({tag, "_start"}, int'(start_address), 0);
    chk({tag, "_fen"},   int'(fetch_unit_en), 0);
    chk({tag, "_rdy"},   int'(in_ready), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_err"},   int'(error), 0);
  endtask

  logic [8:0] prog [12] = '{9'h041, 9'h0A2, 9'h051, 9'h0B3, 9'h120, 9'h1C4,
                            9'h033, 9'h0F0, 9'h155, 9'h12A, 9'h1E1, 9'h1FF};
  logic [8:0] wrap_addr [4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
  logic [8:0] wrap_data [4] = '{9'h101, 9'h0CC, 9'h033, 9'h1AB};

  initial begin
    rst_n = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
    in_valid = 1'b0; in_data = '0; halt = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: base 0, len 12, in_valid held high
    load_start = 1'b1; load_base = 9'h000; load_len = 10'd12;
    tick();
    load_start = 1'b0;
    chk("t1_rdy", int'(in_ready), 1);
    chk("t1_fen0", int'(fetch_unit_en), 0);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = prog[i];
      tick();
      chk("t1_we", int'(imem_we), 1);
      chk("t1_addr", int'(imem_waddr), i);
      chk("t1_data", int'(imem_wdata), int'(prog[i]));
      chk("t1_init", int'(init), (i == 11) ? 1 : 0);
    end
    in_valid = 1'b0;
    chk("t1_start", int'(start_address), 0);
    chk("t1_fen_launch", int'(fetch_unit_en), 1);
    chk("t1_rdy_launch", int'(in_ready), 0);
    chk("t1_busy_launch", int'(busy), 1);
    tick();
    chk("t1_init_run", int'(init), 0);
    chk("t1_fen_run", int'(fetch_unit_en), 1);
    chk("t1_busy_run", int'(busy), 0);
    chk("t1_we_run", int'(imem_we), 0);

    // 2: base 0x1FE, len 4, in_valid every other cycle, issued from RUN
    load_start = 1'b1; load_base = 9'h1FE; load_len = 10'd4;
    tick();
    load_start = 1'b0;
    chk("t2_rdy", int'(in_ready), 1);
    chk("t2_fen", int'(fetch_unit_en), 0);
    begin
      int k;
      logic v;
      k = 0;
      for (int c = 0; c < 8; c++) begin
        v = ((c % 2) == 0) && (k < 4);
        in_valid = v;
        in_data = v ? wrap_data[k] : 9'h1EE;
        tick();
        chk("t2_we", int'(imem_we), int'(v));
        if (v) begin
          chk("t2_addr", int'(imem_waddr), int'(wrap_addr[k]));
          chk("t2_data", int'(imem_wdata), int'(wrap_data[k]));
          chk("t2_init", int'(init), (k == 3) ? 1 : 0);
          k++;
        end
      end
    end
    in_valid = 1'b0;
    chk("t2_start", int'(start_address), 9'h1FE);
    chk("t2_fen_run", int'(fetch_unit_en), 1);
    chk("t2_busy_run", int'(busy), 0);

    // 3: rejected lengths 0 and 513, then len 1 clears error
    load_start = 1'b1; load_base = 9'h007; load_len = 10'd0; in_valid = 1'b1;
    tick();
    load_start = 1'b0;
    chk("t3_err0", int'(error), 1);
    chk("t3_rdy0", int'(in_ready), 0);
    chk("t3_busy0", int'(busy), 0);
    chk("t3_fen0", int'(fetch_unit_en), 1);
    chk("t3_we0", int'(imem_we), 0);
    load_start = 1'b1; load_len = 10'd513;
    tick();
    load_start = 1'b0;
    chk("t3_err513", int'(error), 1);
    chk("t3_rdy513", int'(in_ready), 0);
    chk("t3_we513", int'(imem_we), 0);
    chk("t3_start_kept", int'(start_address), 9'h1FE);
    in_valid = 1'b0;
    load_start = 1'b1; load_base = 9'h005; load_len = 10'd1;
    tick();
    load_start = 1'b0;
    chk("t3_err_clr", int'(error), 0);
    chk("t3_rdy1", int'(in_ready), 1);
    in_valid = 1'b1; in_data = 9'h0AB;
    tick();
    in_valid = 1'b0;
    chk("t3_we1", int'(imem_we), 1);
    chk("t3_addr1", int'(imem_waddr), 9'h005);
    chk("t3_data1", int'(imem_wdata), 9'h0AB);
    chk("t3_init1", int'(init), 1);
    chk("t3_start1", int'(start_address), 9'h005);
    tick();

    // 4: halt + load_start together in RUN, then halt alone
    halt = 1'b1; load_start = 1'b1; load_base = 9'h040; load_len = 10'd2;
    tick();
    halt = 1'b0; load_start = 1'b0;
    chk("t4_rdy", int'(in_ready), 1);
    chk("t4_fen", int'(fetch_unit_en), 0);
    in_valid = 1'b1; in_data = 9'h155;
    tick();
    chk("t4_addr_a", int'(imem_waddr), 9'h040);
    in_data = 9'h0AA;
    tick();
    in_valid = 1'b0;
    chk("t4_addr_b", int'(imem_waddr), 9'h041);
    chk("t4_data_b", int'(imem_wdata), 9'h0AA);
    chk("t4_init", int'(init), 1);
    tick();
    chk("t4_fen_run", int'(fetch_unit_en), 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t4_fen_idle", int'(fetch_unit_en), 0);
    chk("t4_busy_idle", int'(busy), 0);
    chk("t4_rdy_idle", int'(in_ready), 0);

    // 5: reset after the 3rd beat of a len-8 load
    load_start = 1'b1; load_base = 9'h020; load_len = 10'd8;
    tick();
    load_start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 9'(9'h060 + i);
      tick();
    end
    chk("t5_we_pre", int'(imem_we), 1);
    chk("t5_addr_pre", int'(imem_waddr), 9'h022);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t5_rst");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_init_after", int'(init), 0);
    chk("t5_rdy_after", int'(in_ready), 0);
    chk("t5_busy_after", int'(busy), 0);
    in_valid = 1'b1; in_data = 9'h1F0;
    tick();
    chk("t5_we_idle", int'(imem_we), 0);
    chk("t5_rdy_idle", int'(in_ready), 0);
    in_valid = 1'b0;

    // 6: second load_start during LOAD is ignored
    load_start = 1'b1; load_base = 9'h030; load_len = 10'd3;
    tick();
    load_start = 1'b1; load_base = 9'h100; load_len = 10'd5;
    in_valid = 1'b1; in_data = 9'h011;
    tick();
    load_start = 1'b0;
    chk("t6_addr_a", int'(imem_waddr), 9'h030);
    chk("t6_err", int'(error), 0);
    in_data = 9'h022;
    tick();
    chk("t6_addr_b", int'(imem_waddr), 9'h031);
    chk("t6_init_b", int'(init), 0);
    in_data = 9'h033;
    tick();
    in_valid = 1'b0;
    chk("t6_addr_c", int'(imem_waddr), 9'h032);
    chk("t6_data_c", int'(imem_wdata), 9'h033);
    chk("t6_init_c", int'(init), 1);
    chk("t6_start", int'(start_address), 9'h030);
    tick();
    chk("t6_rdy_run", int'(in_ready), 0);
    chk("t6_fen_run", int'(fetch_unit_en), 1);
    chk("t6_we_run", int'(imem_we), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
